urp_pcie_rx_dllp_scheduler: RTL and testbench

//  Arbitrates the RX data-link-layer DLLP return path (32b dllp, valid/ready) between three requesters:
//  - ACK coalescing
//  - NAK scheduling
//  - UpdateFC credit return

---
 rtl/urp_pcie_rx_dllp_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_urp_pcie_rx_dllp_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/urp_pcie_rx_dllp_scheduler.sv
// RX DLLP return-path arbiter: NAK > ACK (coalesce/timeout) > UpdateFC, one DLLP in flight.
// Optional periodic UpdateFC refresh enabled by defining URP_PCIE_DLLP_FC_REFRESH_EN.
module urp_pcie_rx_dllp_scheduler #(
    parameter int unsigned ACK_COALESCE = 4,
    parameter int unsigned ACK_TIMEOUT  = 64,
    parameter int unsigned FC_REFRESH   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ack_req_i,
    input  logic [11:0] ack_seq_i,
    input  logic        nak_req_i,
    input  logic        fc_upd_req_i,
    input  logic [7:0]  fc_hdr_i,
    input  logic [11:0] fc_data_i,
    output logic [31:0] dllp_o,
    output logic        dllp_valid_o,
    input  logic        dllp_ready_i,
    output logic        ack_pending_o,
    output logic        nak_sched_o
);

    localparam int unsigned CW = $clog2(ACK_COALESCE + 1);
    localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(ACK_COALESCE);
    localparam logic [TW-1:0] TMR_MAX = TW'(ACK_TIMEOUT);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t         state_q;
    logic [31:0]    dllp_q;
    logic           valid_q;
    logic [11:0]    last_seq_q;
    logic [CW-1:0]  ack_cnt_q;
    logic [TW-1:0]  ack_timer_q;
    logic           nak_pend_q;
    logic           nak_sched_q;
    logic           fc_pend_q;
    logic [7:0]     fc_hdr_q;
    logic [11:0]    fc_data_q;

    logic [11:0]    seq_eff;
    logic [CW-1:0]  cnt_inc;
    logic           due_reg;
    logic           due_new;
    logic           nak_sched_eff;
    logic           nak_eff;
    logic           refresh_hit;
    logic           fc_eff;
    logic           sel_nak;
    logic           sel_ack;
    logic           sel_fc;
    logic           fc_use_new;
    logic [7:0]     fc_hdr_sel;
    logic [11:0]    fc_data_sel;
    logic [31:0]    dllp_d;

`ifdef URP_PCIE_DLLP_FC_REFRESH_EN
    localparam int unsigned RW = $clog2(FC_REFRESH);
    localparam logic [RW-1:0] RF_LAST = RW'(FC_REFRESH - 1);

    logic [RW-1:0] fc_refresh_q;

    assign refresh_hit = (fc_refresh_q == RF_LAST);

    always_ff @(posedge clk) begin
        if (rst || sel_fc) begin
            fc_refresh_q <= '0;
        end else if (refresh_hit) begin
            fc_refresh_q <= '0;
        end else begin
            fc_refresh_q <= fc_refresh_q + RW'(1);
        end
    end
`else
    logic unused_fc_refresh;

    assign refresh_hit       = 1'b0;
    assign unused_fc_refresh = (FC_REFRESH != 0);
`endif

    // Requests arriving this cycle are folded in so a fresh request loads on the next edge;
    // an ACK already due from registered state defers a same-cycle ack_req_i to the next ACK.
    always_comb begin
        seq_eff = ack_req_i ? ack_seq_i : last_seq_q;
        cnt_inc = ack_cnt_q;
        if (ack_req_i && (ack_cnt_q != CNT_MAX)) begin
            cnt_inc = ack_cnt_q + CW'(1);
        end
        due_reg       = (ack_cnt_q >= CNT_MAX) || (ack_timer_q == TMR_MAX);
        due_new       = !due_reg && ack_req_i && (cnt_inc >= CNT_MAX);
        nak_sched_eff = nak_sched_q && !ack_req_i;
        nak_eff       = nak_pend_q || (nak_req_i && !nak_sched_eff);
        fc_eff        = fc_pend_q || fc_upd_req_i || refresh_hit;

        sel_nak = (state_q == S_IDLE) && nak_eff;
        sel_ack = (state_q == S_IDLE) && !nak_eff && (due_reg || due_new);
        sel_fc  = (state_q == S_IDLE) && !nak_eff && !(due_reg || due_new) && fc_eff;

        // A pending UpdateFC goes out with its latched values; a same-cycle request stays pending.
        fc_use_new  = fc_upd_req_i && !fc_pend_q;
        fc_hdr_sel  = fc_use_new ? fc_hdr_i  : fc_hdr_q;
        fc_data_sel = fc_use_new ? fc_data_i : fc_data_q;

        dllp_d = '0;
        if (sel_nak) begin
            dllp_d = {8'h10, 12'h000, seq_eff};
        end else if (sel_ack) begin
            dllp_d = {8'h00, 12'h000, (due_new ? ack_seq_i : last_seq_q)};
        end else if (sel_fc) begin
            dllp_d = {8'h80, 2'b00, fc_hdr_sel, 2'b00, fc_data_sel};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            dllp_q      <= '0;
            valid_q     <= 1'b0;
            last_seq_q  <= 12'hFFF;
            ack_cnt_q   <= '0;
            ack_timer_q <= '0;
            nak_pend_q  <= 1'b0;
            nak_sched_q <= 1'b0;
            fc_pend_q   <= 1'b0;
            fc_hdr_q    <= '0;
            fc_data_q   <= '0;
        end else begin
            last_seq_q <= seq_eff;

            if (sel_nak || (sel_ack && due_new)) begin
                ack_cnt_q <= '0;
            end else if (sel_ack) begin
                ack_cnt_q <= ack_req_i ? CW'(1) : '0;
            end else begin
                ack_cnt_q <= cnt_inc;
            end

            if (sel_nak || sel_ack) begin
                ack_timer_q <= '0;
            end else if (((ack_cnt_q != '0) || ack_req_i) && (ack_timer_q != TMR_MAX)) begin
                ack_timer_q <= ack_timer_q + TW'(1);
            end

            nak_sched_q <= sel_nak ? 1'b1 : nak_sched_eff;
            nak_pend_q  <= nak_eff && !sel_nak;

            if (fc_upd_req_i) begin
                fc_hdr_q  <= fc_hdr_i;
                fc_data_q <= fc_data_i;
            end
            fc_pend_q <= sel_fc ? (fc_pend_q && fc_upd_req_i) : fc_eff;

            case (state_q)
                S_IDLE: begin
                    if (sel_nak || sel_ack || sel_fc) begin
                        state_q <= S_HOLD;
                        dllp_q  <= dllp_d;
                        valid_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (dllp_ready_i) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign dllp_o        = dllp_q;
    assign dllp_valid_o  = valid_q;
    assign ack_pending_o = (ack_cnt_q != '0);
    assign nak_sched_o   = nak_sched_q;

endmodule

// File: tb/tb_urp_pcie_rx_dllp_scheduler.sv
// Scoreboard bench for urp_pcie_rx_dllp_scheduler: stimulus queues expected DLLPs with their first-valid cycle.
// Build with URP_PCIE_DLLP_FC_REFRESH_EN defined to exercise the periodic UpdateFC refresh.
module tb_urp_pcie_rx_dllp_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        ack_req;
    logic [11:0] ack_seq;
    logic        nak_req;
    logic        fc_upd;
    logic [7:0]  fc_hdr;
    logic [11:0] fc_data;
    logic [31:0] dllp;
    logic        dllp_valid;
    logic        dllp_ready;
    logic        ack_pending;
    logic        nak_sched;

    typedef struct {
        logic [31:0] dllp;
        int unsigned at;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int unsigned cyc = 0;
    logic        in_hold = 1'b0;
    logic [31:0] cur_exp = '0;

    urp_pcie_rx_dllp_scheduler #(
        .ACK_COALESCE(4),
        .ACK_TIMEOUT (64),
        .FC_REFRESH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ack_req_i    (ack_req),
        .ack_seq_i    (ack_seq),
        .nak_req_i    (nak_req),
        .fc_upd_req_i (fc_upd),
        .fc_hdr_i     (fc_hdr),
        .fc_data_i    (fc_data),
        .dllp_o       (dllp),
        .dllp_valid_o (dllp_valid),
        .dllp_ready_i (dllp_ready),
        .ack_pending_o(ack_pending),
        .nak_sched_o  (nak_sched)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] d, input int unsigned at);
        exp_t e;
        e.dllp = d;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ack_req = 1'b0;
        nak_req = 1'b0;
        fc_upd  = 1'b0;
    endtask

    // Monitor: pops one expectation per new DLLP, then holds it against dllp_o until handshake.
    always @(negedge clk) begin
        if (dllp_valid) begin
            if (!in_hold) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_dllp: got %h expected none (cycle %0d)", dllp, cyc);
                    cur_exp = dllp;
                end else begin
                    mon_e = sb.pop_front();
                    check("dllp_body", dllp, mon_e.dllp);
                    check("dllp_first_cycle", 32'(cyc), 32'(mon_e.at));
                    cur_exp = mon_e.dllp;
                end
            end else begin
                check("dllp_stable", dllp, cur_exp);
            end
        end
        in_hold = dllp_valid && !dllp_ready;
    end

    initial begin
        int unsigned t;
        rst        = 1'b1;
        ack_req    = 1'b0;
        ack_seq    = '0;
        nak_req    = 1'b0;
        fc_upd     = 1'b0;
        fc_hdr     = '0;
        fc_data    = '0;
        dllp_ready = 1'b1;
        repeat (3) tick();
        check("rst_valid", 32'(dllp_valid), 32'd0);
        check("rst_dllp", dllp, 32'h0);
        check("rst_ack_pending", 32'(ack_pending), 32'd0);
        check("rst_nak_sched", 32'(nak_sched), 32'd0);

`ifdef URP_PCIE_DLLP_FC_REFRESH_EN
        // Refresh: one UpdateFC request, then the same credits resent every 16 cycles
        rst     = 1'b0;
        fc_upd  = 1'b1;
        fc_hdr  = 8'h10;
        fc_data = 12'h040;
        t = cyc;
        push(32'h8004_0040, t + 1);
        push(32'h8004_0040, t + 17);
        push(32'h8004_0040, t + 33);
        push(32'h8004_0040, t + 49);
        tick();
        repeat (56) tick();
`else
        rst = 1'b0;
        tick();

        // Coalesce: four good TLPs back-to-back
        for (int i = 0; i < 4; i++) begin
            ack_req = 1'b1;
            ack_seq = 12'(i);
            if (i == 3) push(32'h0000_0003, cyc + 1);
            tick();
            if (i == 0) check("coalesce_pending", 32'(ack_pending), 32'd1);
        end
        check("coalesce_pending_clr", 32'(ack_pending), 32'd0);
        repeat (4) tick();

        // Timeout: single TLP, ACK after ACK_TIMEOUT+1 cycles
        ack_req = 1'b1;
        ack_seq = 12'd5;
        push(32'h0000_0005, cyc + 65);
        tick();
        repeat (70) tick();

        // NAK: duplicate NAK ignored while scheduled, cleared by next good TLP
        ack_req = 1'b1;
        ack_seq = 12'd7;
        tick();
        nak_req = 1'b1;
        push(32'h1000_0007, cyc + 1);
        tick();
        check("nak_sched_set", 32'(nak_sched), 32'd1);
        check("nak_ack_cleared", 32'(ack_pending), 32'd0);
        nak_req = 1'b1;
        tick();
        repeat (3) tick();
        ack_req = 1'b1;
        ack_seq = 12'd8;
        tick();
        check("nak_sched_clr", 32'(nak_sched), 32'd0);
        check("nak_then_pending", 32'(ack_pending), 32'd1);
        nak_req = 1'b1;
        push(32'h1000_0008, cyc + 1);
        tick();
        repeat (4) tick();

        // Arbitration: ACK due and UpdateFC together under 10 cycles of back-pressure
        dllp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ack_req = 1'b1;
            ack_seq = 12'(10 + i);
            if (i == 3) begin
                fc_upd  = 1'b1;
                fc_hdr  = 8'h10;
                fc_data = 12'h040;
                t = cyc;
                push(32'h0000_000D, t + 1);
                push(32'h8004_0040, t + 12);
            end
            tick();
        end
        repeat (9) tick();
        dllp_ready = 1'b1;
        repeat (6) tick();

        // Same-cycle NAK, good TLP and UpdateFC: NAK carries the new seq, FC follows
        ack_req = 1'b1;
        ack_seq = 12'd20;
        nak_req = 1'b1;
        fc_upd  = 1'b1;
        fc_hdr  = 8'h01;
        fc_data = 12'h002;
        t = cyc;
        push(32'h1000_0014, t + 1);
        push(32'h8000_4002, t + 3);
        tick();
        check("nak_absorbs_ack", 32'(ack_pending), 32'd0);
        repeat (5) tick();

        // Reset while holding a NAK under back-pressure; held DLLP dropped
        dllp_ready = 1'b0;
        ack_req = 1'b1;
        ack_seq = 12'd30;
        tick();
        nak_req = 1'b1;
        push(32'h1000_001E, cyc + 1);
        tick();
        check("hold_valid", 32'(dllp_valid), 32'd1);
        check("hold_nak_sched", 32'(nak_sched), 32'd1);
        rst     = 1'b1;
        ack_req = 1'b1;
        ack_seq = 12'd55;
        tick();
        sb.delete();
        check("midrst_valid", 32'(dllp_valid), 32'd0);
        check("midrst_dllp", dllp, 32'h0);
        check("midrst_ack_pending", 32'(ack_pending), 32'd0);
        check("midrst_nak_sched", 32'(nak_sched), 32'd0);
        rst        = 1'b0;
        dllp_ready = 1'b1;
        nak_req    = 1'b1;
        push(32'h1000_0FFF, cyc + 1);
        tick();
        repeat (4) tick();

        // Without refresh: a single UpdateFC is never repeated
        fc_upd  = 1'b1;
        fc_hdr  = 8'h10;
        fc_data = 12'h040;
        push(32'h8004_0040, cyc + 1);
        tick();
        repeat (40) tick();
`endif

        for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL missing_dllp: got none expected %h (%0d outstanding)", sb[0].dllp, sb.size());
        end
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
